// File: rtl/pcgen_pkg.sv
// Shared types and constants for the fetch PC generator.
package pcgen_pkg;

  // Controller states: normal fetch, post-redirect squash window, sticky fault.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_e;

  localparam int          DEF_FLUSHLEN = 2;
  localparam logic [31:0] DEF_RESETPC  = 32'h0000_0000;

  // Instruction fetch needs word alignment, so any set bit in [1:0] is a fault.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/pcgen_brtarget.sv
// Control-transfer target computation: branch/JAL use expc+imm, JALR uses
// rs1+imm with bit 0 cleared. Sums wrap modulo 2^DWIDTH.
module brtarget
  import pcgen_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              isjalr_i,
  input  logic [DWIDTH-1:0] expc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  output logic [DWIDTH-1:0] target_o,
  output logic              misaligned_o
);

  logic [DWIDTH-1:0] jalrSum;

  // JALR wins whenever it is asserted, even alongside JAL or branch flags.
  always_comb begin
    jalrSum = rs1_i + imm_i;
    if (isjalr_i) begin
      target_o = {jalrSum[DWIDTH-1:1], 1'b0};
    end else begin
      target_o = expc_i + imm_i;
    end
    misaligned_o = isMisaligned(target_o[1:0]);
  end

endmodule

// File: rtl/pcgen.sv
// Fetch PC generator: sequential PC advance, execute-stage redirects with a
// fixed-width flush window, sticky trap on misaligned targets, and a
// saturating count of successful redirects.
module pcgen
  import pcgen_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESETPC  = DWIDTH'(DEF_RESETPC),
  parameter int                FLUSHLEN = DEF_FLUSHLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exvalid,
  input  logic              isbranch,
  input  logic              isjal,
  input  logic              isjalr,
  input  logic              brnch,
  input  logic [DWIDTH-1:0] expc,
  input  logic [DWIDTH-1:0] imm,
  input  logic [DWIDTH-1:0] rs1,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] pcplus4,
  output logic              flush,
  output logic              trap,
  output logic [DWIDTH-1:0] brcount
);

  // The counter holds the number of flush cycles still to come after the
  // current one, so it never needs to represent FLUSHLEN itself.
  localparam int              CNTW    = (FLUSHLEN > 1) ? $clog2(FLUSHLEN) : 1;
  localparam logic [CNTW-1:0] CNTLOAD = CNTW'(FLUSHLEN - 1);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] brcount_q, brcount_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              trap_q, trap_d;

  logic              taken;
  logic [DWIDTH-1:0] pcSeq;
  logic [DWIDTH-1:0] target;
  logic              misaligned;

  brtarget #(
    .DWIDTH(DWIDTH)
  ) u_brtarget (
    .isjalr_i    (isjalr),
    .expc_i      (expc),
    .imm_i       (imm),
    .rs1_i       (rs1),
    .target_o    (target),
    .misaligned_o(misaligned)
  );

  // Next-state logic: redirects beat stall in RUN; FLUSH ignores the execute
  // stage and keeps fetching; TRAP freezes everything until reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    brcount_d = brcount_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    trap_d    = trap_q;
    taken     = exvalid & ((isbranch & brnch) | isjal | isjalr);
    pcSeq     = stall ? pc_q : pc_q + DWIDTH'(4);
    unique case (state_q)
      RUN: begin
        if (taken && !misaligned) begin
          pc_d    = target;
          flush_d = 1'b1;
          cnt_d   = CNTLOAD;
          state_d = FLUSH;
          if (brcount_q != '1) begin
            brcount_d = brcount_q + DWIDTH'(1);
          end
        end else if (taken) begin
          trap_d  = 1'b1;
          flush_d = 1'b1;
          state_d = TRAP;
        end else begin
          pc_d    = pcSeq;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        pc_d = pcSeq;
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNTW'(1);
          flush_d = 1'b1;
        end else begin
          flush_d = 1'b0;
          state_d = RUN;
        end
      end
      TRAP: begin
        trap_d  = 1'b1;
        flush_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register with synchronous reset overriding every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESETPC;
      brcount_q <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      brcount_q <= brcount_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      trap_q    <= trap_d;
    end
  end

  assign pc      = pc_q;
  assign pcplus4 = pc_q + DWIDTH'(4);
  assign flush   = flush_q;
  assign trap    = trap_q;
  assign brcount = brcount_q;

endmodule

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: directed scenarios, a randomized run against
// a behavioural model, and a saturation run on a narrow 8-bit instance.
module tb_pcgen;

  localparam int          FLUSHLEN = 2;
  localparam logic [31:0] RESETPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        exvalid = 1'b0;
  logic        isbranch = 1'b0;
  logic        isjal = 1'b0;
  logic        isjalr = 1'b0;
  logic        brnch = 1'b0;
  logic [31:0] expc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] pc, pcplus4, brcount;
  logic        flush, trap;

  logic [7:0]  sPc, sPcplus4, sBrcount;
  logic        sFlush, sTrap;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: remaining flush cycles counted down from FLUSHLEN.
  logic [31:0] mPc = '0;
  logic [31:0] mBr = '0;
  int          mFlushLeft = 0;
  bit          mTrap = 1'b0;
  int          sExpect = 0;

  always #5 clk = ~clk;

  pcgen #(
    .DWIDTH  (32),
    .RESETPC (RESETPC),
    .FLUSHLEN(FLUSHLEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .exvalid (exvalid),
    .isbranch(isbranch),
    .isjal   (isjal),
    .isjalr  (isjalr),
    .brnch   (brnch),
    .expc    (expc),
    .imm     (imm),
    .rs1     (rs1),
    .pc      (pc),
    .pcplus4 (pcplus4),
    .flush   (flush),
    .trap    (trap),
    .brcount (brcount)
  );

  pcgen #(
    .DWIDTH  (8),
    .RESETPC (8'h00),
    .FLUSHLEN(FLUSHLEN)
  ) dutSmall (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .exvalid (exvalid),
    .isbranch(isbranch),
    .isjal   (isjal),
    .isjalr  (isjalr),
    .brnch   (brnch),
    .expc    (expc[7:0]),
    .imm     (imm[7:0]),
    .rs1     (rs1[7:0]),
    .pc      (sPc),
    .pcplus4 (sPcplus4),
    .flush   (sFlush),
    .trap    (sTrap),
    .brcount (sBrcount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    logic [31:0] tgt;
    if (reset) begin
      mPc = RESETPC;
      mBr = '0;
      mFlushLeft = 0;
      mTrap = 1'b0;
    end else if (mTrap) begin
      mPc = mPc;
    end else if (mFlushLeft > 0) begin
      mFlushLeft--;
      if (!stall) mPc = mPc + 32'd4;
    end else if (exvalid && ((isbranch && brnch) || isjal || isjalr)) begin
      tgt = isjalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (expc + imm);
      if (tgt % 4 != 0) begin
        mTrap = 1'b1;
      end else begin
        mPc = tgt;
        mFlushLeft = FLUSHLEN;
        if (mBr != 32'hFFFF_FFFF) mBr = mBr + 32'd1;
      end
    end else if (!stall) begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic compareAll();
    checkOutput("pc", pc, mPc);
    checkOutput("pcplus4", pcplus4, mPc + 32'd4);
    checkOutput("flush", 32'(flush), 32'((mFlushLeft > 0) || mTrap));
    checkOutput("trap", 32'(trap), 32'(mTrap));
    checkOutput("brcount", brcount, mBr);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input logic r, input logic st, input logic ev,
                               input logic ib, input logic ij, input logic ijr,
                               input logic br, input logic [31:0] e,
                               input logic [31:0] im, input logic [31:0] r1);
    reset = r; stall = st; exvalid = ev; isbranch = ib; isjal = ij;
    isjalr = ijr; brnch = br; expc = e; imm = im; rs1 = r1;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input logic st);
    applyStimulus(1'b0, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic ib, ij, ijr, ev, st, r;
    logic [31:0] e, im, r1;
    int trapCycles;

    @(negedge clk);

    // Reset state and sequential fetch.
    doReset();
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_trap", 32'(trap), 32'h0);
    checkOutput("rst_brcount", brcount, 32'h0);
    idle(1'b0); checkOutput("seq_pc4", pc, 32'h4);
    idle(1'b0); checkOutput("seq_pc8", pc, 32'h8);
    idle(1'b0); checkOutput("seq_pcC", pc, 32'hC);

    // Taken branch: one-cycle latency, two-cycle flush window.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, '0);
    checkOutput("br_pc", pc, 32'h120);
    checkOutput("br_flush1", 32'(flush), 32'h1);
    checkOutput("br_count", brcount, 32'h1);
    idle(1'b0);
    checkOutput("br_flush2", 32'(flush), 32'h1);
    checkOutput("br_pc2", pc, 32'h124);
    idle(1'b0);
    checkOutput("br_flush3", 32'(flush), 32'h0);
    checkOutput("br_pc3", pc, 32'h128);

    // Second taken branch during FLUSH is ignored.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 32'h40, '0);
    checkOutput("ign_pc", pc, 32'h124);
    checkOutput("ign_count", brcount, 32'h1);
    idle(1'b0);
    checkOutput("ign_pc2", pc, 32'h128);

    // JAL target wraps around the address space.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, '0);
    checkOutput("wrap_pc", pc, 32'h10);
    checkOutput("wrap_trap", 32'(trap), 32'h0);
    idle(1'b0);
    idle(1'b0);
    // Redirect beats stall; stall neither extends nor shortens flush.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h8, '0);
    checkOutput("stallbr_pc", pc, 32'h308);
    checkOutput("stallbr_count", brcount, 32'h2);
    idle(1'b1);
    checkOutput("stallfl_pc", pc, 32'h308);
    checkOutput("stallfl_flush", 32'(flush), 32'h1);
    idle(1'b1);
    checkOutput("stallfl_end", 32'(flush), 32'h0);

    // Reset in the second FLUSH cycle.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, '0);
    idle(1'b0);
    doReset();
    checkOutput("midfl_pc", pc, RESETPC);
    checkOutput("midfl_flush", 32'(flush), 32'h0);
    idle(1'b0);
    checkOutput("midfl_run", pc, RESETPC + 32'd4);

    // Misaligned JALR with stall traps and holds until reset.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h0, 32'h203);
    checkOutput("trap_set", 32'(trap), 32'h1);
    checkOutput("trap_pc", pc, 32'h0);
    checkOutput("trap_flush", 32'(flush), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, $urandom & 32'hFFFF_FFFC,
                    32'h40, '0);
    end
    checkOutput("trap_hold_pc", pc, 32'h0);
    checkOutput("trap_hold_cnt", brcount, 32'h0);
    doReset();
    checkOutput("trap_clr", 32'(trap), 32'h0);

    // Randomized run against the model.
    trapCycles = 0;
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 39) == 0) || (trapCycles > 4);
      st  = ($urandom_range(0, 3) == 0);
      ev  = ($urandom_range(0, 2) != 0);
      ib  = ($urandom_range(0, 2) == 0);
      ij  = ($urandom_range(0, 5) == 0);
      ijr = ($urandom_range(0, 5) == 0);
      e   = $urandom & 32'hFFFF_FFFC;
      im  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      r1  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
      applyStimulus(r, st, ev, ib, ij, ijr, 1'($urandom), e, im, r1);
      trapCycles = mTrap ? trapCycles + 1 : 0;
    end

    // Saturation of brcount on the 8-bit instance.
    doReset();
    sExpect = 0;
    for (int n = 1; n <= 260; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      sExpect = (n > 255) ? 255 : n;
      checkOutput("small_brcount", 32'(sBrcount), 32'(sExpect));
      idle(1'b0);
      idle(1'b0);
    end
    checkOutput("small_sat", 32'(sBrcount), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
